mux_n_stream: RTL
=================

// Module: mux_n_stream
// PURPOSE
//  Parametrised N-channel stream multiplexer; successor to the fixed 8:1 combinational mux.
//  Selects one of N_CH valid/ready input channels and forwards it through a single registered output stage.
//  Two selection modes: addressed (addr picks the channel) or round-robin arbitration.
//  Active-low chip select gates acceptance. Sits between multi-source producers and a single shared consumer.
// PARAMETERS
//  WIDTH  8                  data width per channel
//  N_CH   8                  number of input channels, 2..64, need not be a power of 2
//  SEL_W  $clog2(N_CH)       channel index width (derived, do not override)
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             asynchronous, active-high reset
//  nCS        in   1             active-low select; 1 = accept nothing
//  mode       in   1             0 = addressed, 1 = round-robin
//  addr       in   SEL_W         channel index used in addressed mode
//  in_data    in   N_CH*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N_CH          per-channel valid
//  in_ready   out  N_CH          per-channel ready; at most one bit set
//  out_data   out  WIDTH         registered data; 0 whenever out_valid = 0
//  out_ch     out  SEL_W         channel index of out_data; 0 whenever out_valid = 0
//  out_valid  out  1             output holds a word
//  out_ready  in   1             consumer accepts the word
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = N_CH-1.
//    rr_ptr = N_CH-1 gives channel 0 first priority.
//  - Output stage: one entry; load_en = !out_valid | out_ready.
//    Sustains 1 word/cycle; latency is 1 cycle from input handshake to out_valid.
//  - Grant (combinational, evaluated only when !nCS and load_en):
//    - mode = 0: grant = addr if addr < N_CH and in_valid[addr]; otherwise no grant.
//    - mode = 1: grant = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... mod N_CH.
//      Wrap-around: after N_CH-1 the search continues at 0. No valid channel = no grant.
//  - in_ready[g] = 1 only for the granted channel g. Transfer = in_valid[g] & in_ready[g].
//  - On transfer: out_data <= channel g data, out_ch <= g, out_valid <= 1.
//    Round-robin mode only: rr_ptr <= g.
//  - If out_ready and no transfer: out_valid <= 0, out_data <= 0, out_ch <= 0.
//  - If out_valid and !out_ready: output holds stable; all in_ready = 0 (no overwrite).
//  - nCS = 1: all in_ready = 0. A word already held still drains normally on out_ready.
//    nCS never clears out_valid.
//  - Mode or addr change: takes effect on the next grant. rr_ptr is kept unchanged across mode = 0 periods.
//  - Simultaneous out_ready and new transfer in one cycle: new word replaces old, out_valid stays 1.
//  - Reset mid-transfer: the word is dropped; the upstream transfer is treated as not taken.
//  - No combinational path from out_ready to out_data. in_ready depends combinationally on
//    out_ready, nCS, mode, addr and in_valid.
// STRUCTURE
//  - Package mux_pkg: MODE_ADDR = 1'b0, MODE_RR = 1'b1; clog2 helper function.
//  - Sub-module rr_pick #(N_CH): inputs req[N_CH], ptr[SEL_W].
//    Outputs gnt_vld and gnt_idx[SEL_W]: rotate-priority search starting at ptr+1.
//  - Top level: addressed-mode decode, grant mux, in_ready fan-out, output register, rr_ptr register.
// TESTING
//  1. Addressed mode, N_CH=8, WIDTH=8, nCS=0, out_ready=1, addr=3, in_valid=8'hFF, ch3 data=8'hA5
//     -> in_ready=8'h08; next cycle out_valid=1, out_data=A5, out_ch=3.
//  2. Round-robin, in_valid=8'b1000_0101 held, out_ready=1, after reset
//     -> grants 0,2,7,0,2,7 on consecutive cycles; out_ch follows one cycle later. Covers wrap-around.
//  3. Backpressure: word loaded, out_ready=0 for 4 cycles -> out_data and out_ch stable, in_ready=0.
//     Then out_ready=1 with ch5 valid -> word consumed and ch5 loaded in the same cycle.
//  4. nCS=1 while out_valid=1 and out_ready=1 -> word drains, out_valid=0, out_data=0, in_ready=0 thereafter.
//  5. N_CH=5, mode=0, addr=6, in_valid=5'h1F -> no grant, in_ready=0, out_valid stays 0.
//  6. rst pulsed mid-stream (between clock edges) -> out_valid, out_data and out_ch go 0 immediately.
//     After release, first RR grant is the lowest valid channel.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package mux_pkg;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   // Index width for n items; never less than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r++;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester after ptr, wrapping to channel 0.
module rr_pick
   import mux_pkg::*;
#(
   parameter int unsigned N_CH  = 8,
   parameter int unsigned SEL_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_vld,
   output logic [SEL_W-1:0] gnt_idx
);

   logic             hi_vld;
   logic [SEL_W-1:0] hi_idx;
   logic             lo_vld;
   logic [SEL_W-1:0] lo_idx;

   // Lowest requester above ptr wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (req[i] && !lo_vld) begin
            lo_vld = 1'b1;
            lo_idx = SEL_W'(i);
         end
         if (req[i] && !hi_vld && (SEL_W'(i) > ptr)) begin
            hi_vld = 1'b1;
            hi_idx = SEL_W'(i);
         end
      end
      gnt_vld = lo_vld;
      gnt_idx = hi_vld ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/mux_n_stream.sv
// N-channel valid/ready multiplexer with addressed or round-robin selection
// feeding a single registered output stage.
module mux_n_stream
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_CH  = 8,
   parameter int unsigned SEL_W = clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  nCS,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      addr,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [SEL_W-1:0] rr_ptr;
   logic             rr_vld;
   logic [SEL_W-1:0] rr_idx;
   logic             addr_vld;
   logic             load_en;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] sel_data;

   rr_pick #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_vld (rr_vld),
      .gnt_idx (rr_idx)
   );

   // Addressed decode; out-of-range addresses never match any channel.
   always_comb begin
      addr_vld = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if ((addr == SEL_W'(i)) && in_valid[i]) begin
            addr_vld = 1'b1;
         end
      end
   end

   // Grant only when selected and the output stage can take a word.
   always_comb begin
      load_en   = !out_valid || out_ready;
      grant_idx = (mode == MODE_RR) ? rr_idx : addr;
      grant_vld = !nCS && load_en && ((mode == MODE_RR) ? rr_vld : addr_vld);
   end

   // One-hot ready fan-out and data select for the granted channel.
   always_comb begin
      in_ready = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (grant_vld && (grant_idx == SEL_W'(i))) begin
            in_ready[i] = 1'b1;
            sel_data    = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output register and round-robin pointer; idle output is forced to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= SEL_W'(N_CH - 1);
      end else if (grant_vld) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_ch    <= grant_idx;
         if (mode == MODE_RR) begin
            rr_ptr <= grant_idx;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end
   end

endmodule
